axi_write_injector: RTL and testbench

//   Parametrised single-clock AXI4 write-burst injector. It accepts one command (address, length, seed)
//   on a valid/ready port and issues one INCR write burst with generated pattern data. It then waits
//   for the write response and reports completion status. It sits between a control block and a memory-side AXI slave.

---
 rtl/axi_write_injector_if.sv | 50 +++++
 rtl/axi_write_injector.sv | 135 +++++++++++++
 tb/tb_axi_write_injector.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_injector_if.sv
// Command/completion port and AXI4 write channels of the write-burst injector.
// master = injector side, slave = control block plus memory-side AXI slave.
interface axi_write_injector_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 24
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [ADDR_WIDTH-1:0]     cmd_addr;
   logic [7:0]                cmd_len;
   logic [31:0]               cmd_seed;
   logic                      done_valid;
   logic [1:0]                done_resp;

   logic [ID_WIDTH-1:0]       data_awid;
   logic [ADDR_WIDTH-1:0]     data_awaddr;
   logic [7:0]                data_awlen;
   logic [2:0]                data_awsize;
   logic [1:0]                data_awburst;
   logic                      data_awvalid;
   logic                      data_awready;
   logic [DATA_WIDTH-1:0]     data_wdata;
   logic [DATA_WIDTH/8-1:0]   data_wstrb;
   logic                      data_wlast;
   logic                      data_wvalid;
   logic                      data_wready;
   logic [ID_WIDTH-1:0]       data_bid;
   logic [1:0]                data_bresp;
   logic                      data_bvalid;
   logic                      data_bready;

   // Every channel is valid/ready: a transfer happens on a rising edge with both high;
   // the sender holds valid and payload stable until then and never withdraws valid.
   modport master (
      input  cmd_valid, cmd_addr, cmd_len, cmd_seed,
      input  data_awready, data_wready, data_bid, data_bresp, data_bvalid,
      output cmd_ready, done_valid, done_resp,
      output data_awid, data_awaddr, data_awlen, data_awsize, data_awburst, data_awvalid,
      output data_wdata, data_wstrb, data_wlast, data_wvalid, data_bready
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, cmd_seed,
      output data_awready, data_wready, data_bid, data_bresp, data_bvalid,
      input  cmd_ready, done_valid, done_resp,
      input  data_awid, data_awaddr, data_awlen, data_awsize, data_awburst, data_awvalid,
      input  data_wdata, data_wstrb, data_wlast, data_wvalid, data_bready
   );
endinterface

// File: rtl/axi_write_injector.sv
// Single-command AXI4 INCR write-burst injector: one command in, one patterned burst out,
// then a one-cycle completion pulse carrying the (ID-checked) write response.
module axi_write_injector #(
   parameter int                  DATA_WIDTH = 256,
   parameter int                  ADDR_WIDTH = 32,
   parameter int                  ID_WIDTH   = 24,
   parameter logic [ID_WIDTH-1:0] INJECT_ID  = '0
) (
   input  logic                   data_aclk,
   input  logic                   data_aresetn,
   axi_write_injector_if.master   bus,
   output logic [1:0]             dbg_state_o
);
   localparam int                    LANES     = DATA_WIDTH / 32;
   localparam int                    OFFS      = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [7:0]              beat_q, beat_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    wlast_q, wlast_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    done_valid_q, done_valid_d;
   logic [1:0]              done_resp_q, done_resp_d;
   logic                    aw_ok, w_ok;

   always_ff @(posedge data_aclk or negedge data_aresetn) begin
      if (!data_aresetn) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         beat_q       <= '0;
         wdata_q      <= '0;
         wlast_q      <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         done_valid_q <= 1'b0;
         done_resp_q  <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         wdata_q      <= wdata_d;
         wlast_q      <= wlast_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         done_valid_q <= done_valid_d;
         done_resp_q  <= done_resp_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beat_d       = beat_q;
      wdata_d      = wdata_q;
      wlast_d      = wlast_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      done_valid_d = 1'b0;
      done_resp_d  = done_resp_q;
      // A channel is finished once its valid has dropped or its final transfer happens now.
      aw_ok        = !awvalid_q || bus.data_awready;
      w_ok         = !wvalid_q || (bus.data_wready && wlast_q);

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               addr_d    = bus.cmd_addr & ADDR_MASK;
               len_d     = bus.cmd_len;
               beat_d    = '0;
               for (int k = 0; k < LANES; k++) begin
                  wdata_d[32*k +: 32] = bus.cmd_seed + 32'(k);
               end
               wlast_d   = (bus.cmd_len == 8'd0);
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = S_BURST;
            end
         end
         S_BURST: begin
            if (awvalid_q && bus.data_awready) begin
               awvalid_d = 1'b0;
            end
            if (wvalid_q && bus.data_wready) begin
               if (wlast_q) begin
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
               end else begin
                  beat_d  = beat_q + 8'd1;
                  wlast_d = ((beat_q + 8'd1) == len_q);
                  // Every lane advances by LANES per beat, wrapping mod 2^32.
                  for (int k = 0; k < LANES; k++) begin
                     wdata_d[32*k +: 32] = wdata_q[32*k +: 32] + 32'(LANES);
                  end
               end
            end
            if (aw_ok && w_ok) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.data_bvalid) begin
               done_valid_d = 1'b1;
               done_resp_d  = (bus.data_bid != INJECT_ID) ? 2'b10 : bus.data_bresp;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cmd_ready    = (state_q == S_IDLE);
   assign bus.done_valid   = done_valid_q;
   assign bus.done_resp    = done_resp_q;
   assign bus.data_awid    = INJECT_ID;
   assign bus.data_awaddr  = addr_q;
   assign bus.data_awlen   = len_q;
   assign bus.data_awsize  = 3'(OFFS);
   assign bus.data_awburst = 2'b01;
   assign bus.data_awvalid = awvalid_q;
   assign bus.data_wdata   = wdata_q;
   assign bus.data_wstrb   = '1;
   assign bus.data_wlast   = wlast_q;
   assign bus.data_wvalid  = wvalid_q;
   assign bus.data_bready  = (state_q == S_RESP);
   assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_axi_write_injector.sv
// Randomised bench for axi_write_injector: command driver, reactive AXI slave and a
// negedge monitor comparing every handshake against expected queues from a pattern model.
module tb_axi_write_injector;
  localparam int             DW    = 256;
  localparam int             AW    = 32;
  localparam int             IDW   = 24;
  localparam int             LANES = DW / 32;
  localparam logic [IDW-1:0] INJ_ID = 24'h000003;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  axi_write_injector_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus ();

  axi_write_injector #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .INJECT_ID(INJ_ID)
  ) dut (
    .data_aclk    (clk),
    .data_aresetn (rst_n),
    .bus          (bus),
    .dbg_state_o  (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  logic [AW+7:0]  exp_aw_q[$];
  logic [DW:0]    exp_w_q[$];
  logic [1:0]     exp_done_q[$];
  logic [IDW+1:0] b_cfg_q[$];

  int          aw_block = 0;
  bit          ready_rand = 1'b0;
  bit          aw_seen = 1'b0, w_last_seen = 1'b0, premature = 1'b0, b_drop = 1'b0;
  int          b_wait = 0;
  int          w_beats = 0;
  int          done_count = 0;
  int          aw_count = 0;
  bit          aw_stall_prev = 1'b0, w_stall_prev = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] prev_awaddr;
  logic [DW:0]   prev_w;

  task automatic check(input string name, input logic [DW+7:0] act, input logic [DW+7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [31:0] seed, input int i);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[32*k +: 32] = seed + 32'(i * LANES + k);
    return r;
  endfunction

  // ---------------- monitor + reactive slave ----------------
  always @(negedge clk) begin
    logic [AW+7:0]  ea;
    logic [DW:0]    ew;
    logic [IDW+1:0] cfg;
    if (rst_n) begin
      if (aw_stall_prev) begin
        check("aw_hold_valid", bus.data_awvalid, 1);
        check("aw_hold_addr", bus.data_awaddr, prev_awaddr);
      end
      if (w_stall_prev) begin
        check("w_hold_valid", bus.data_wvalid, 1);
        check("w_hold_data", {bus.data_wlast, bus.data_wdata}, prev_w);
      end
      if (b_drop) begin
        bus.data_bvalid = 1'b0;
        b_drop = 1'b0;
      end
      if (bus.data_bready && !(aw_seen && w_last_seen)) premature = 1'b1;

      if (aw_block > 0) begin
        bus.data_awready = 1'b0;
        aw_block--;
      end else begin
        bus.data_awready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.data_wready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;

      if (bus.data_awvalid && bus.data_awready) begin
        aw_count++;
        if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          ea = exp_aw_q.pop_front();
          check("awaddr", bus.data_awaddr, ea[AW+7:8]);
          check("awlen", bus.data_awlen, ea[7:0]);
          check("awid", bus.data_awid, INJ_ID);
          check("awsize", bus.data_awsize, 3'd5);
          check("awburst", bus.data_awburst, 2'b01);
        end
        aw_seen = 1'b1;
      end
      if (bus.data_wvalid && bus.data_wready) begin
        w_beats++;
        if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          ew = exp_w_q.pop_front();
          check("wdata", bus.data_wdata, ew[DW-1:0]);
          check("wlast", bus.data_wlast, ew[DW]);
          check("wstrb", bus.data_wstrb, {(DW/8){1'b1}});
          if (ew[DW]) w_last_seen = 1'b1;
        end
      end

      if (!bus.data_bvalid && aw_seen && w_last_seen && b_cfg_q.size() > 0) begin
        if (b_wait > 0) b_wait--;
        else begin
          cfg = b_cfg_q.pop_front();
          bus.data_bid    = cfg[IDW+1:2];
          bus.data_bresp  = cfg[1:0];
          bus.data_bvalid = 1'b1;
        end
      end
      if (bus.data_bvalid && bus.data_bready) begin
        check("bready_before_aw_and_wlast", premature, 0);
        b_drop = 1'b1;
        aw_seen = 1'b0;
        w_last_seen = 1'b0;
        premature = 1'b0;
        w_beats = 0;
        b_wait = $urandom_range(0, 3);
      end

      if (bus.done_valid) begin
        done_count++;
        check("done_pulse_width", prev_done, 0);
        if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_resp", bus.done_resp, exp_done_q.pop_front());
      end
      prev_done     = bus.done_valid;
      aw_stall_prev = bus.data_awvalid && !bus.data_awready;
      prev_awaddr   = bus.data_awaddr;
      w_stall_prev  = bus.data_wvalid && !bus.data_wready;
      prev_w        = {bus.data_wlast, bus.data_wdata};
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_cmd(input logic [AW-1:0] addr, input logic [7:0] len, input logic [31:0] seed,
                          input logic [1:0] bresp, input bit bad_id, input bit keep);
    int n = 0;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_seed  = seed;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    exp_aw_q.push_back({addr & ~AW'(DW/8 - 1), len});
    for (int i = 0; i <= int'(len); i++) exp_w_q.push_back({(i == int'(len)), beat_data(seed, i)});
    exp_done_q.push_back(bad_id ? 2'b10 : bresp);
    b_cfg_q.push_back({(bad_id ? IDW'(INJ_ID + 24'd1) : INJ_ID), bresp});
    @(negedge clk);
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_aw_q.size() + exp_w_q.size() + exp_done_q.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", exp_aw_q.size() + exp_w_q.size() + exp_done_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_awvalid"}, bus.data_awvalid, 0);
    check({tag, "_wvalid"}, bus.data_wvalid, 0);
    check({tag, "_wlast"}, bus.data_wlast, 0);
    check({tag, "_bready"}, bus.data_bready, 0);
    check({tag, "_done_valid"}, bus.done_valid, 0);
    check({tag, "_awaddr"}, bus.data_awaddr, 0);
    check({tag, "_awlen"}, bus.data_awlen, 0);
    check({tag, "_wdata"}, bus.data_wdata, 0);
    check({tag, "_done_resp"}, bus.done_resp, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int d0, a0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_seed = '0;
    bus.data_awready = 1'b0; bus.data_wready = 1'b0;
    bus.data_bvalid = 1'b0; bus.data_bid = '0; bus.data_bresp = '0;

    #3 check_reset_outputs("por");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single beat, slave always ready.
    ready_rand = 1'b0;
    send_cmd(32'h0000_1000, 8'd0, 32'h10, 2'b00, 1'b0, 1'b0);
    wait_idle();

    // Lane values wrap through zero; unaligned address gets its low bits dropped.
    send_cmd(32'h0000_2013, 8'd3, 32'hFFFF_FFFE, 2'b00, 1'b0, 1'b0);
    wait_idle();

    // AW held off: all W beats go first, AW must stay stable.
    aw_block = 12;
    send_cmd(32'h0000_3000, 8'd3, 32'h100, 2'b00, 1'b0, 1'b0);
    wait_idle();

    // Error responses: SLVERR/DECERR passthrough and ID mismatch.
    send_cmd(32'h0000_4000, 8'd1, 32'h55, 2'b11, 1'b0, 1'b0);
    wait_idle();
    send_cmd(32'h0000_5000, 8'd2, 32'h66, 2'b00, 1'b1, 1'b0);
    wait_idle();

    // Command valid held across a whole burst: exactly one capture per completion.
    d0 = done_count;
    a0 = aw_count;
    send_cmd(32'h0000_6000, 8'd5, 32'hA0, 2'b01, 1'b0, 1'b1);
    send_cmd(32'h0000_7040, 8'd2, 32'hB0, 2'b00, 1'b0, 1'b0);
    wait_idle();
    check("held_valid_done_count", done_count - d0, 2);
    check("held_valid_aw_count", aw_count - a0, 2);

    // Asynchronous reset in the middle of a burst.
    aw_block = 100;
    send_cmd(32'h0000_8000, 8'd7, 32'h1234, 2'b00, 1'b0, 1'b0);
    begin
      int n = 0;
      while (w_beats < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reach_beat2", (w_beats >= 2), 1);
    end
    d0 = done_count;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midburst");
    exp_aw_q.delete(); exp_w_q.delete(); exp_done_q.delete(); b_cfg_q.delete();
    aw_block = 0; aw_seen = 1'b0; w_last_seen = 1'b0; premature = 1'b0; b_drop = 1'b0;
    w_beats = 0; aw_stall_prev = 1'b0; w_stall_prev = 1'b0; prev_done = 1'b0;
    bus.data_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", bus.cmd_ready, 1);
    repeat (10) @(negedge clk);
    check("no_done_after_reset", done_count - d0, 0);

    // Random commands with random back-pressure and response codes.
    ready_rand = 1'b1;
    for (int t = 0; t < 24; t++) begin
      send_cmd($urandom, 8'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
